irrigation_scheduler: RTL
=========================

Name: irrigation_scheduler

Overview:
Sequencing controller for the irrigation plant: it owns the tank inlet valve, sprinkler valve and drip valve and runs them as timed phases. Tank fill has priority, irrigation runs only with the tank at or above mid-level, and a cool-down follows every irrigation run. Invalid level-sensor combinations and fill timeouts latch a fault. It sits between the sensor inputs (h, m, l, us, ua, t) and the valve and display datapath, consuming the 1 s tick from the clock divider.

Parameters:
FILL_TIMEOUT_S, 60, max seconds in FILL before h must assert
SPRINKLE_S, 10, sprinkler run length in seconds
DRIP_S, 20, drip run length in seconds
COOLDOWN_S, 5, all-valves-off pause after any irrigation run
CNT_W, 8, width of the seconds timer; all durations must be in 1..2^CNT_W-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_1s  in  1  one-clk-wide strobe, once per second
h  in  1  tank level high switch (1 = water present)
m  in  1  tank level mid switch
l  in  1  tank level low switch
us  in  1  soil dry (1 = needs water)
ua  in  1  air dry (1 = low humidity)
t  in  1  temperature high
fault_clr  in  1  one-clk pulse to clear a latched fault
valve_inlet  out  1  tank inlet valve
valve_sprinkler  out  1  sprinkler valve
valve_drip  out  1  drip valve
fault  out  1  latched fault flag
phase  out  3  IDLE=0, FILL=1, SPRINKLE=2, DRIP=3, COOLDOWN=4, FAULT=5
remaining  out  CNT_W  seconds left in the current timed phase; 0 in IDLE and FAULT
runs_done  out  8  count of completed irrigation runs, wraps 255 -> 0

Behaviour:
- Reset (synchronous, active-high): phase=IDLE, all valves 0, fault=0, remaining=0, runs_done=0, and input registers cleared to 0.
- All sensor inputs and fault_clr pass through one register stage (_q). The FSM acts only on _q values. All outputs are registered. An input change therefore reaches the outputs 2 clk edges later.
- Level error: lvl_err = (h_q & ~m_q) | (m_q & ~l_q).
- Priority order within any state: rst, then lvl_err, then all other conditions.
- IDLE:
  - lvl_err -> FAULT.
  - Else if ~m_q -> FILL, loading timer with FILL_TIMEOUT_S.
  - Else if us_q & ua_q & t_q -> DRIP, loading DRIP_S.
  - Else if us_q -> SPRINKLE, loading SPRINKLE_S.
  - Else stay in IDLE.
- FILL: valve_inlet=1.
  - h_q -> IDLE.
  - On tick_1s with timer==1 and ~h_q -> FAULT (timeout).
  - Otherwise decrement on tick_1s.
- SPRINKLE / DRIP: the respective valve is 1 and the other two are 0.
  - Timer decrements on tick_1s. Tick with timer==1 -> COOLDOWN, loading COOLDOWN_S, and runs_done increments.
  - Early abort when ~us_q or ~l_q -> COOLDOWN. runs_done does not increment.
  - Abort and tick in the same cycle: abort wins.
- COOLDOWN: all valves 0. Tick with timer==1 -> IDLE. Otherwise decrement on tick_1s.
- FAULT: all valves 0, fault=1. fault_clr_q & ~lvl_err -> IDLE with fault=0. fault_clr_q while lvl_err is still asserted is ignored.
- Timer loads on the edge that enters a phase. A tick coinciding with the entry edge is ignored. A phase loaded with N ends on the Nth subsequent tick.
- At most one valve is 1 in any cycle. Valve outputs change on the same edge as the phase change.
- Mode (sprinkler or drip) is chosen only at entry from IDLE. Later changes to ua or t do not switch modes mid-run.
- Reset asserted mid-phase aborts immediately. Valves are 0 on the next edge.

Decomposition:
- Shared package irrigation_pkg holds the phase encoding constants (IDLE..FAULT, 3 bits) and the default durations.
- One sub-module, sec_timer: a loadable down-counter of width CNT_W with inputs load, load_val and tick, and outputs count and last (count==1 & tick). The FSM and the runs_done counter stay in irrigation_scheduler.

Test Plan:
Bench parameters: FILL_TIMEOUT_S=6, SPRINKLE_S=3, DRIP_S=4, COOLDOWN_S=2; tick_1s every 10 clk.
1. Normal fill: l=1, m=0, h=0, then set m=h=1 after 3 ticks -> valve_inlet=1 with phase=1, then IDLE 2 clk after h rises; no fault.
2. Fill timeout: l=1, m=0, h held 0 -> exactly 6 ticks after FILL entry, phase=5, fault=1, valve_inlet=0.
3. Sprinkler run: h=m=l=1, us=1, ua=0 -> phase=2 for 3 ticks (remaining shows 3,2,1), then COOLDOWN for 2 ticks, then IDLE; runs_done=1.
4. Drip run and abort: us=ua=t=1 -> phase=3; drop us after 2 ticks -> COOLDOWN 2 clk later, valve_drip=0, runs_done unchanged.
5. Level error: h=1, m=0, l=1 from any state -> FAULT; fault_clr while the error persists -> stays in FAULT; correct sensors, then fault_clr -> IDLE with fault=0.
6. Reset mid-SPRINKLE plus wrap: rst pulse -> all outputs 0 on the next edge; 256 completed runs -> runs_done=0.

Source files
------------

// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - phase encoding, default durations and valve decode for the irrigation scheduler
package irrigation_pkg;

    localparam logic [2:0] PH_IDLE     = 3'd0;
    localparam logic [2:0] PH_FILL     = 3'd1;
    localparam logic [2:0] PH_SPRINKLE = 3'd2;
    localparam logic [2:0] PH_DRIP     = 3'd3;
    localparam logic [2:0] PH_COOLDOWN = 3'd4;
    localparam logic [2:0] PH_FAULT    = 3'd5;

    localparam int DEF_FILL_TIMEOUT_S = 60;
    localparam int DEF_SPRINKLE_S     = 10;
    localparam int DEF_DRIP_S         = 20;
    localparam int DEF_COOLDOWN_S     = 5;
    localparam int DEF_CNT_W          = 8;

    typedef struct packed {
        logic inlet;
        logic sprinkler;
        logic drip;
    } valves_t;

    // One-hot by construction: at most one valve is ever open.
    function automatic valves_t phaseValves(input logic [2:0] ph);
        valves_t v;
        v = '0;
        case (ph)
            PH_FILL:     v.inlet     = 1'b1;
            PH_SPRINKLE: v.sprinkler = 1'b1;
            PH_DRIP:     v.drip      = 1'b1;
            default:     v           = '0;
        endcase
        return v;
    endfunction

    // A higher switch wet while a lower one is dry cannot happen with working sensors.
    function automatic logic levelError(input logic h, input logic m, input logic l);
        return (h & ~m) | (m & ~l);
    endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// rtl/irrigation_scheduler_if.sv - sensor inputs and valve/status outputs of the irrigation scheduler
interface irrigation_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             tick_1s;
    logic             h;
    logic             m;
    logic             l;
    logic             us;
    logic             ua;
    logic             t;
    logic             fault_clr;
    logic             valve_inlet;
    logic             valve_sprinkler;
    logic             valve_drip;
    logic             fault;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic [7:0]       runs_done;

    modport master (
        output tick_1s, h, m, l, us, ua, t, fault_clr,
        input  valve_inlet, valve_sprinkler, valve_drip, fault, phase, remaining, runs_done
    );

    modport slave (
        input  tick_1s, h, m, l, us, ua, t, fault_clr,
        output valve_inlet, valve_sprinkler, valve_drip, fault, phase, remaining, runs_done
    );
endinterface

// File: rtl/irrigation_scheduler_sec_timer.sv
// rtl/irrigation_scheduler_sec_timer.sv - loadable seconds down-counter with last-tick strobe
module sec_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    // Load outranks tick so a tick on the entry edge is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = tick && (count == CNT_W'(1));
endmodule

// File: rtl/irrigation_scheduler.sv
// rtl/irrigation_scheduler.sv - timed fill/sprinkle/drip/cooldown sequencer with latched level fault
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int FILL_TIMEOUT_S = DEF_FILL_TIMEOUT_S,
    parameter int SPRINKLE_S     = DEF_SPRINKLE_S,
    parameter int DRIP_S         = DEF_DRIP_S,
    parameter int COOLDOWN_S     = DEF_COOLDOWN_S,
    parameter int CNT_W          = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    irrigation_scheduler_if.slave bus
);
    logic hQ, mQ, lQ, usQ, uaQ, tQ, faultClrQ;
    logic [2:0] phaseR;
    logic [2:0] nextPhase;
    valves_t valvesR;
    logic faultR;
    logic [7:0] runsDone;
    logic runInc;
    logic lvlErr;
    logic timerLoad;
    logic [CNT_W-1:0] timerLoadVal;
    logic [CNT_W-1:0] timerCount;
    logic timerLast;

    assign lvlErr = levelError(hQ, mQ, lQ);

    sec_timer #(.CNT_W(CNT_W)) uTimer (
        .clk     (clk),
        .rst     (rst),
        .load    (timerLoad),
        .loadVal (timerLoadVal),
        .tick    (bus.tick_1s),
        .count   (timerCount),
        .last    (timerLast)
    );

    always_comb begin
        nextPhase = phaseR;
        runInc    = 1'b0;
        if (lvlErr) begin
            nextPhase = PH_FAULT;
        end else begin
            case (phaseR)
                PH_IDLE: begin
                    if (!mQ)                 nextPhase = PH_FILL;
                    else if (usQ & uaQ & tQ) nextPhase = PH_DRIP;
                    else if (usQ)            nextPhase = PH_SPRINKLE;
                end
                PH_FILL: begin
                    if (hQ)             nextPhase = PH_IDLE;
                    else if (timerLast) nextPhase = PH_FAULT;
                end
                PH_SPRINKLE, PH_DRIP: begin
                    // An abort ends the run early and is not counted as completed.
                    if (!usQ || !lQ) begin
                        nextPhase = PH_COOLDOWN;
                    end else if (timerLast) begin
                        nextPhase = PH_COOLDOWN;
                        runInc    = 1'b1;
                    end
                end
                PH_COOLDOWN: begin
                    if (timerLast) nextPhase = PH_IDLE;
                end
                PH_FAULT: begin
                    if (faultClrQ) nextPhase = PH_IDLE;
                end
                default: nextPhase = PH_IDLE;
            endcase
        end
    end

    // Idle and fault load zero so remaining reads 0 there.
    always_comb begin
        timerLoad = (nextPhase != phaseR);
        case (nextPhase)
            PH_FILL:     timerLoadVal = CNT_W'(FILL_TIMEOUT_S);
            PH_SPRINKLE: timerLoadVal = CNT_W'(SPRINKLE_S);
            PH_DRIP:     timerLoadVal = CNT_W'(DRIP_S);
            PH_COOLDOWN: timerLoadVal = CNT_W'(COOLDOWN_S);
            default:     timerLoadVal = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hQ        <= 1'b0;
            mQ        <= 1'b0;
            lQ        <= 1'b0;
            usQ       <= 1'b0;
            uaQ       <= 1'b0;
            tQ        <= 1'b0;
            faultClrQ <= 1'b0;
            phaseR    <= PH_IDLE;
            valvesR   <= '0;
            faultR    <= 1'b0;
            runsDone  <= 8'd0;
        end else begin
            hQ        <= bus.h;
            mQ        <= bus.m;
            lQ        <= bus.l;
            usQ       <= bus.us;
            uaQ       <= bus.ua;
            tQ        <= bus.t;
            faultClrQ <= bus.fault_clr;
            phaseR    <= nextPhase;
            valvesR   <= phaseValves(nextPhase);
            faultR    <= (nextPhase == PH_FAULT);
            if (runInc) begin
                runsDone <= runsDone + 8'd1;
            end
        end
    end

    assign bus.phase           = phaseR;
    assign bus.valve_inlet     = valvesR.inlet;
    assign bus.valve_sprinkler = valvesR.sprinkler;
    assign bus.valve_drip      = valvesR.drip;
    assign bus.fault           = faultR;
    assign bus.remaining       = timerCount;
    assign bus.runs_done       = runsDone;
endmodule
